uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
Serial UART transmitter, 8N1 framing: 1 start bit (0), 8 data bits LSB-first, 1 stop bit (1). Default divisor gives 19200 baud at 50 MHz.
It is the transmit-side counterpart of the team's UART receiver, which samples mid-bit using the same 2604-clock bit period. Host logic (command/response path) loads a byte with a one-cycle strobe. `uart_tx` reports completion through a sticky done flag.
The TX line idles high and is driven from a flop, so it is glitch-free.

Parameters:
BAUD_DIV, 2604, clocks per bit period; legal range ≥ 4; counter width = $clog2(BAUD_DIV).

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
trmt  input  1  one-cycle start strobe; honoured only in IDLE
tx_data  input  8  byte to send; sampled on the clock edge where trmt is accepted
TX  output  1  serial line; idle/reset = 1
tx_done  output  1  sticky: set when a frame's stop bit completes; cleared by an accepted trmt

Behaviour:
- Reset (asynchronous):
  - TX = 1, tx_done = 0, state IDLE.
  - Shift register = all ones; baud and bit counters = 0.
  - Reset asserted mid-frame aborts the frame immediately: TX returns to 1 with no further clock needed.
- Datapath:
  - 10-bit shift register; TX = shift_reg[0] (a flop output, no combinational path).
  - On accept, load {1'b1, tx_data, 1'b0}.
  - On each shift, right-shift and fill the MSB with 1.
- Baud counter:
  - Loaded with BAUD_DIV-1 on accept and on every shift.
  - Decrements while TRANSMITTING.
  - shift = (baud_cnt == 0) && TRANSMITTING.
  - Never decrements in IDLE.
- Bit counter (4-bit):
  - Cleared on accept; increments on each shift.
  - Frame ends on the shift that takes it to 10.
- FSM, 2 states:
  - IDLE:
    - trmt=1 → accept: load shift register, clear tx_done, go to TRANSMITTING.
    - trmt=0 → stay; TX = 1.
  - TRANSMITTING:
    - The 10th shift (bit_cnt==9 && shift) → set tx_done, go to IDLE.
    - trmt is ignored for the whole frame, including the completing edge.
- Timing, with trmt accepted at edge N and B = BAUD_DIV:
  - Start bit: TX = 0 over [N, N+B).
  - Data bit i (i = 0..7): over [N+(i+1)B, N+(i+2)B).
  - Stop bit: TX = 1 over [N+9B, N+10B).
  - At edge N+10B: tx_done = 1, state = IDLE.
  - TX stays 1 from the stop bit onwards.
- Back-to-back frames:
  - trmt at the first IDLE cycle (edge N+10B+1) is legal.
  - Minimum frame spacing = 10B+1 cycles.
  - The only idle gap is that single extra cycle, which extends the stop bit.
- tx_done:
  - Holds until the next accepted trmt; clears on the same edge the new start bit begins.
  - trmt while tx_done=1 in IDLE is a normal accept.
- tx_data is not required to be stable after the accept edge; the byte is captured internally.

Decomposition:
- Shared package uart_pkg holds:
  - BAUD_DIV_19200 = 2604
  - FRAME_BITS = 10
  - state typedef { IDLE, TRANSMITTING }
- Receiver and transmitter both import uart_pkg.
- No sub-module needed: the baud counter, bit counter, shifter and FSM are a single flat block.
- A top-level uart wrapper, instantiating the receiver plus `uart_tx`, is a separate deliverable.

Test Plan:
1. Reset, then idle 1000 clocks → TX = 1 and tx_done = 0 throughout.
2. trmt with tx_data=8'hA5 (BAUD_DIV=2604), sample TX at mid-bit offsets 1302 + k·2604 → sequence 0,1,0,1,0,0,1,0,1,1. tx_done rises exactly 26040 cycles after the accept edge.
3. Pulse trmt with 8'hFF at cycle 5000 of a frame carrying 8'h3C → frame 8'h3C unchanged; no restart; tx_done asserts once.
4. Loopback into the team receiver, with bytes 8'h00, 8'hFF, 8'h55 sent back-to-back (trmt on the cycle after each tx_done) → receiver rdy and rx_data match each byte, in order.
5. Deassert rst_n at bit 4 of a frame → TX = 1 asynchronously and tx_done = 0. After release, trmt with 8'h81 → clean full frame.
6. BAUD_DIV=4 instance, send 8'h01 → exact waveform 0000 1111 0000×7 1111. tx_done asserts at cycle 40.

Source files
------------

// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART constants and FSM state encoding.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int BAUD_DIV_19200 = 2604;
    localparam int FRAME_BITS     = 10;

    typedef enum logic {
        IDLE         = 1'b0,
        TRANSMITTING = 1'b1
    } uart_state_t;

endpackage : uart_pkg

`default_nettype wire

// File: rtl/uart_tx.sv
// ============================================================================
// Module      : uart_tx
// Description : 8N1 UART transmitter, LSB first, sticky completion flag.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module uart_tx
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_19200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       TX,
    output logic       tx_done
);

    localparam int                CNT_W         = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0]  c_BAUD_RELOAD = CNT_W'(BAUD_DIV - 1);
    localparam logic [3:0]        c_LAST_BIT    = 4'(FRAME_BITS - 1);

    uart_state_t           r_state;
    uart_state_t           w_state_nxt;
    logic [FRAME_BITS-1:0] r_shift;
    logic [CNT_W-1:0]      r_baud_cnt;
    logic [3:0]            r_bit_cnt;
    logic                  r_tx_done;
    logic                  w_accept;
    logic                  w_shift;
    logic                  w_frame_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // trmt is only looked at in IDLE, so strobes during a frame are dropped
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_shift     = 1'b0;
        w_frame_end = 1'b0;
        case (r_state)
            IDLE: begin
                if (trmt) begin
                    w_accept    = 1'b1;
                    w_state_nxt = TRANSMITTING;
                end
            end
            TRANSMITTING: begin
                if (r_baud_cnt == '0) begin
                    w_shift = 1'b1;
                    if (r_bit_cnt == c_LAST_BIT) begin
                        w_frame_end = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift    <= '1;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_tx_done  <= 1'b0;
        end else if (w_accept) begin
            r_shift    <= {1'b1, tx_data, 1'b0};
            r_baud_cnt <= c_BAUD_RELOAD;
            r_bit_cnt  <= '0;
            r_tx_done  <= 1'b0;
        end else if (w_shift) begin
            // ones shifted in keep the line high once the stop bit is out
            r_shift    <= {1'b1, r_shift[FRAME_BITS-1:1]};
            r_baud_cnt <= c_BAUD_RELOAD;
            r_bit_cnt  <= r_bit_cnt + 4'd1;
            if (w_frame_end) begin
                r_tx_done <= 1'b1;
            end
        end else if (r_state == TRANSMITTING) begin
            r_baud_cnt <= r_baud_cnt - 1'b1;
        end
    end

    assign TX      = r_shift[0];
    assign tx_done = r_tx_done;

endmodule : uart_tx

`default_nettype wire

// File: tb/tb_uart_tx.sv
// ============================================================================
// Module      : tb_uart_tx
// Description : Directed self-checking bench for uart_tx at three divisors.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_uart_tx;

    localparam int B_S = 2604;
    localparam int B_F = 16;
    localparam int B_4 = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       trmt_s, trmt_f, trmt_4;
    logic [7:0] data_s, data_f, data_4;
    logic       tx_s, tx_f, tx_4;
    logic       done_s, done_f, done_4;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    uart_tx #(.BAUD_DIV(B_S)) u_dut_s (
        .clk(clk), .rst_n(rst_n), .trmt(trmt_s), .tx_data(data_s),
        .TX(tx_s), .tx_done(done_s)
    );

    uart_tx #(.BAUD_DIV(B_F)) u_dut_f (
        .clk(clk), .rst_n(rst_n), .trmt(trmt_f), .tx_data(data_f),
        .TX(tx_f), .tx_done(done_f)
    );

    uart_tx #(.BAUD_DIV(B_4)) u_dut_4 (
        .clk(clk), .rst_n(rst_n), .trmt(trmt_4), .tx_data(data_4),
        .TX(tx_4), .tx_done(done_4)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        int bad;
        trmt_s = 1'b0; trmt_f = 1'b0; trmt_4 = 1'b0;
        data_s = 8'h00; data_f = 8'h00; data_4 = 8'h00;
        rst_n  = 1'b0;
        tick(3);
        n_vec++;
        if (tx_s !== 1'b1) begin
            n_err++; $display("FAIL reset_tx: got %b expected 1", tx_s);
        end
        n_vec++;
        if (done_s !== 1'b0) begin
            n_err++; $display("FAIL reset_done: got %b expected 0", done_s);
        end
        #2 rst_n = 1'b1;
        bad = 0;
        for (int k = 0; k < 1000; k++) begin
            tick(1);
            if ({tx_s, tx_f, tx_4, done_s, done_f, done_4} !== 6'b111000) bad++;
        end
        n_vec++;
        if (bad != 0) begin
            n_err++; $display("FAIL idle_1000: %0d bad cycles, expected 0", bad);
        end
    endtask

    task automatic test_frame_a5();
        logic [9:0] seq;
        seq = 10'b1101001010;
        data_s = 8'hA5; trmt_s = 1'b1;
        tick(1);
        trmt_s = 1'b0; data_s = 8'h00;
        for (int k = 1; k <= 10 * B_S; k++) begin
            tick(1);
            if (k % B_S == B_S / 2) begin
                n_vec++;
                if (tx_s !== seq[k / B_S]) begin
                    n_err++;
                    $display("FAIL a5_bit%0d: got %b expected %b", k / B_S, tx_s, seq[k / B_S]);
                end
            end
            if (k == 10 * B_S - 1) begin
                n_vec++;
                if (done_s !== 1'b0) begin
                    n_err++; $display("FAIL a5_done_early: got %b expected 0", done_s);
                end
            end
        end
        n_vec++;
        if (done_s !== 1'b1) begin
            n_err++; $display("FAIL a5_done_26040: got %b expected 1", done_s);
        end
    endtask

    task automatic test_ignore_trmt();
        logic [9:0] seq;
        int bad_done;
        seq = 10'b1001111000;
        bad_done = 0;
        data_f = 8'h3C; trmt_f = 1'b1;
        tick(1);
        trmt_f = 1'b0; data_f = 8'h00;
        for (int k = 1; k <= 10 * B_F; k++) begin
            if (k == 50 || k == 10 * B_F) begin
                trmt_f = 1'b1; data_f = 8'hFF;
            end
            tick(1);
            trmt_f = 1'b0;
            if (k % B_F == B_F / 2) begin
                n_vec++;
                if (tx_f !== seq[k / B_F]) begin
                    n_err++;
                    $display("FAIL ign_bit%0d: got %b expected %b", k / B_F, tx_f, seq[k / B_F]);
                end
            end
            if (k < 10 * B_F && done_f !== 1'b0) bad_done++;
        end
        n_vec++;
        if (bad_done != 0) begin
            n_err++; $display("FAIL ign_done_early: %0d cycles high, expected 0", bad_done);
        end
        n_vec++;
        if (done_f !== 1'b1) begin
            n_err++; $display("FAIL ign_done_end: got %b expected 1", done_f);
        end
        tick(1);
        n_vec++;
        if ({tx_f, done_f} !== 2'b11) begin
            n_err++; $display("FAIL ign_no_restart: got tx,done=%b expected 11", {tx_f, done_f});
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [3];
        logic [9:0] rx;
        bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h55;
        data_f = bytes[0]; trmt_f = 1'b1;
        for (int b = 0; b < 3; b++) begin
            tick(1);
            trmt_f = 1'b0; data_f = ~bytes[b];
            n_vec++;
            if ({tx_f, done_f} !== 2'b00) begin
                n_err++; $display("FAIL b2b%0d_accept: got tx,done=%b expected 00", b, {tx_f, done_f});
            end
            rx = '0;
            for (int k = 1; k <= 10 * B_F; k++) begin
                tick(1);
                if (k % B_F == B_F / 2) rx[k / B_F] = tx_f;
            end
            n_vec++;
            if ({tx_f, done_f} !== 2'b11) begin
                n_err++; $display("FAIL b2b%0d_done: got tx,done=%b expected 11", b, {tx_f, done_f});
            end
            n_vec++;
            if (rx !== {1'b1, bytes[b], 1'b0}) begin
                n_err++; $display("FAIL b2b%0d_rx: got %b expected %b", b, rx, {1'b1, bytes[b], 1'b0});
            end
            if (b < 2) begin
                trmt_f = 1'b1; data_f = bytes[b + 1];
            end
        end
    endtask

    task automatic test_reset_midframe();
        logic [9:0] seq;
        int bad;
        seq = 10'b1100000010;
        data_f = 8'h81; trmt_f = 1'b1;
        tick(1);
        trmt_f = 1'b0;
        tick(5 * B_F + 3);
        n_vec++;
        if (tx_f !== 1'b0) begin
            n_err++; $display("FAIL rst_pre_bit4: got %b expected 0", tx_f);
        end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({tx_f, done_f, done_s} !== 3'b100) begin
            n_err++; $display("FAIL rst_async: got tx,done_f,done_s=%b expected 100", {tx_f, done_f, done_s});
        end
        #2 rst_n = 1'b1;
        bad = 0;
        for (int k = 0; k < 2 * B_F; k++) begin
            tick(1);
            if ({tx_f, done_f} !== 2'b10) bad++;
        end
        n_vec++;
        if (bad != 0) begin
            n_err++; $display("FAIL rst_idle_after: %0d bad cycles, expected 0", bad);
        end
        trmt_f = 1'b1;
        tick(1);
        trmt_f = 1'b0;
        for (int k = 1; k <= 10 * B_F; k++) begin
            tick(1);
            if (k % B_F == B_F / 2) begin
                n_vec++;
                if (tx_f !== seq[k / B_F]) begin
                    n_err++;
                    $display("FAIL rst81_bit%0d: got %b expected %b", k / B_F, tx_f, seq[k / B_F]);
                end
            end
        end
        n_vec++;
        if (done_f !== 1'b1) begin
            n_err++; $display("FAIL rst81_done: got %b expected 1", done_f);
        end
    endtask

    task automatic test_baud4();
        logic [39:0] wave;
        wave = 40'hF0000000F0;
        data_4 = 8'h01; trmt_4 = 1'b1;
        tick(1);
        trmt_4 = 1'b0; data_4 = 8'hFE;
        for (int k = 0; k < 40; k++) begin
            if (k > 0) tick(1);
            n_vec++;
            if ({tx_4, done_4} !== {wave[k], 1'b0}) begin
                n_err++;
                $display("FAIL b4_cyc%0d: got tx,done=%b expected %b", k, {tx_4, done_4}, {wave[k], 1'b0});
            end
        end
        tick(1);
        n_vec++;
        if ({tx_4, done_4} !== 2'b11) begin
            n_err++; $display("FAIL b4_done40: got tx,done=%b expected 11", {tx_4, done_4});
        end
    endtask

    initial begin
        test_reset();
        test_frame_a5();
        test_ignore_trmt();
        test_back_to_back();
        test_reset_midframe();
        test_baud4();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_uart_tx

`default_nettype wire
